// File: rtl/cornice_pkg.sv
// Shared definitions for the cornice_mobile sprite block.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: FSM state codes, default coordinate/velocity widths and mod_sub(),
// the modular difference used by the wrap-aware hit test.
package cornice_pkg;

    localparam int PW_DEF = 11;   // coordinate width
    localparam int VW_DEF = 6;    // signed velocity width

    // Update sequencer states.
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] CALC_X = 2'd1;
    localparam logic [1:0] CALC_Y = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    // (a - b) mod m for a, b already in [0, m). The borrow case is folded as
    // a + (m - b), which never exceeds m, so no extra width is needed.
    function automatic logic [PW_DEF-1:0] mod_sub(input logic [PW_DEF-1:0] a,
                                                  input logic [PW_DEF-1:0] b,
                                                  input logic [PW_DEF-1:0] m);
        return (a >= b) ? (a - b) : (a + (m - b));
    endfunction

endpackage

// File: rtl/cornice_mobile_asse_mover.sv
// One-axis position stepper: pos + v with torus wrap or wall bounce.
// Latency: combinational (registered by the caller).
// Backpressure: none; the caller multiplexes X and Y through one instance.
// Ports: pos/v in, modulus m, sprite extent s_size, modo (0 wrap, 1 bounce)
//        -> new_pos, new_v (negated on bounce, saturating), urto (bounced).
module asse_mover #(
    parameter int PW = 11,
    parameter int VW = 6
) (
    input  logic [PW-1:0] pos,
    input  logic [VW-1:0] v,
    input  logic [PW-1:0] m,
    input  logic [PW-1:0] s_size,
    input  logic          modo,
    output logic [PW-1:0] new_pos,
    output logic [VW-1:0] new_v,
    output logic          urto
);

    // Two spare bits: one for the sign, one so pos + v can exceed 2^PW.
    logic signed [PW+1:0] sum;
    logic signed [PW+1:0] m_s;
    logic signed [PW+1:0] lim;
    logic        [VW-1:0] v_neg;

    always_comb begin
        m_s   = $signed({2'b00, m});
        lim   = m_s - $signed({2'b00, s_size});
        sum   = $signed({2'b00, pos}) + $signed({{(PW+2-VW){v[VW-1]}}, v});
        // The most negative velocity has no positive twin; clamp to max.
        v_neg = (v == {1'b1, {(VW-1){1'b0}}}) ? {1'b0, {(VW-1){1'b1}}}
                                              : ({VW{1'b0}} - v);

        new_pos = pos;
        new_v   = v;
        urto    = 1'b0;
        if (!modo) begin
            if (sum >= m_s) begin
                new_pos = PW'(sum - m_s);
            end else if (sum[PW+1]) begin
                new_pos = PW'(sum + m_s);
            end else begin
                new_pos = PW'(sum);
            end
        end else begin
            if (sum > lim) begin
                new_pos = PW'(lim);
                new_v   = v_neg;
                urto    = 1'b1;
            end else if (sum[PW+1]) begin
                new_pos = '0;
                new_v   = v_neg;
                urto    = 1'b1;
            end else begin
                new_pos = PW'(sum);
            end
        end
    end

endmodule

// File: rtl/cornice_mobile.sv
// Moving rectangle (or hollow frame) sprite with per-frame motion and pixel hit test.
// Latency: hit test 1 cycle; FRAME_TICK to new X_POS/Y_POS 3 cycles.
// Backpressure: none; FRAME_TICK outside RUN is dropped, LOAD always wins.
// Ports: CLK, RST (sync, active high); FRAME_TICK, LOAD, X_INIT/Y_INIT, VX/VY, MODO
//        control motion; X_CONTROLLO/Y_CONTROLLO scan in -> CONFERMA;
//        X_POS/Y_POS committed position, URTO bounce pulse, OCCUPATO update busy.
// Build option: define CORNICE_EN for a hollow frame of thickness SPESSORE.
module cornice_mobile
    import cornice_pkg::*;
#(
    parameter int H         = 1280,
    parameter int V         = 1024,
    parameter int LARGHEZZA = 100,
    parameter int ALTEZZA   = 100,
    parameter int SPESSORE  = 6,
    parameter int PW        = PW_DEF,
    parameter int VW        = VW_DEF,
    parameter int X0        = 0,
    parameter int Y0        = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FRAME_TICK,
    input  logic          LOAD,
    input  logic [PW-1:0] X_INIT,
    input  logic [PW-1:0] Y_INIT,
    input  logic [VW-1:0] VX,
    input  logic [VW-1:0] VY,
    input  logic          MODO,
    input  logic [PW-1:0] X_CONTROLLO,
    input  logic [PW-1:0] Y_CONTROLLO,
    output logic          CONFERMA,
    output logic [PW-1:0] X_POS,
    output logic [PW-1:0] Y_POS,
    output logic          URTO,
    output logic          OCCUPATO
);

    localparam logic [PW-1:0] H_C = PW'(H);
    localparam logic [PW-1:0] V_C = PW'(V);
    localparam logic [PW-1:0] L_C = PW'(LARGHEZZA);
    localparam logic [PW-1:0] A_C = PW'(ALTEZZA);

    logic [1:0]    state_q,   state_d;
    logic [PW-1:0] x_pos_q,   x_pos_d;
    logic [PW-1:0] y_pos_q,   y_pos_d;
    logic [VW-1:0] vx_q,      vx_d;
    logic [VW-1:0] vy_q,      vy_d;
    logic [PW-1:0] x_sh_q,    x_sh_d;
    logic [PW-1:0] y_sh_q,    y_sh_d;
    logic [VW-1:0] vx_sh_q,   vx_sh_d;
    logic [VW-1:0] vy_sh_q,   vy_sh_d;
    logic          modo_q,    modo_d;
    logic          bounce_q,  bounce_d;
    logic          urto_q,    urto_d;
    logic          conferma_q, conferma_d;

    // Shared axis stepper: X is fed in CALC_X, Y otherwise (only used in CALC_Y).
    logic [PW-1:0] mv_pos, mv_m, mv_s, mv_new_pos;
    logic [VW-1:0] mv_v, mv_new_v;
    logic          mv_modo, mv_urto;

    always_comb begin
        if (state_q == CALC_X) begin
            mv_pos  = x_pos_q;
            mv_v    = vx_q;
            mv_m    = H_C;
            mv_s    = L_C;
            mv_modo = MODO;      // MODO is captured this cycle
        end else begin
            mv_pos  = y_pos_q;
            mv_v    = vy_q;
            mv_m    = V_C;
            mv_s    = A_C;
            mv_modo = modo_q;    // Y uses the mode captured in CALC_X
        end
    end

    asse_mover #(.PW(PW), .VW(VW)) u_asse_mover (
        .pos     (mv_pos),
        .v       (mv_v),
        .m       (mv_m),
        .s_size  (mv_s),
        .modo    (mv_modo),
        .new_pos (mv_new_pos),
        .new_v   (mv_new_v),
        .urto    (mv_urto)
    );

    function automatic logic span_hit(input logic [PW-1:0] c,
                                      input logic [PW-1:0] p,
                                      input logic [PW-1:0] m,
                                      input logic [PW-1:0] sz);
        return (c < m) && (mod_sub(c, p, m) < sz);
    endfunction

`ifdef CORNICE_EN
    localparam logic [PW-1:0] HALF = PW'(SPESSORE / 2);
    localparam logic [PW-1:0] LI_C = PW'(LARGHEZZA - SPESSORE);
    localparam logic [PW-1:0] AI_C = PW'(ALTEZZA - SPESSORE);
    logic [PW-1:0] xi, yi;

    // Inner origin = position + SPESSORE/2, wrapped without widening.
    always_comb begin
        xi = (x_pos_q >= H_C - HALF) ? (x_pos_q - (H_C - HALF)) : (x_pos_q + HALF);
        yi = (y_pos_q >= V_C - HALF) ? (y_pos_q - (V_C - HALF)) : (y_pos_q + HALF);
        conferma_d = span_hit(X_CONTROLLO, x_pos_q, H_C, L_C)
                  && span_hit(Y_CONTROLLO, y_pos_q, V_C, A_C)
                  && !(span_hit(X_CONTROLLO, xi, H_C, LI_C)
                    && span_hit(Y_CONTROLLO, yi, V_C, AI_C));
    end
`else
    always_comb begin
        conferma_d = span_hit(X_CONTROLLO, x_pos_q, H_C, L_C)
                  && span_hit(Y_CONTROLLO, y_pos_q, V_C, A_C);
    end
`endif

    always_comb begin
        state_d  = state_q;
        x_pos_d  = x_pos_q;
        y_pos_d  = y_pos_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        x_sh_d   = x_sh_q;
        y_sh_d   = y_sh_q;
        vx_sh_d  = vx_sh_q;
        vy_sh_d  = vy_sh_q;
        modo_d   = modo_q;
        bounce_d = bounce_q;
        urto_d   = 1'b0;

        case (state_q)
            RUN: begin
                if (FRAME_TICK) begin
                    state_d = CALC_X;
                end
            end
            CALC_X: begin
                x_sh_d   = mv_new_pos;
                vx_sh_d  = mv_new_v;
                modo_d   = MODO;
                bounce_d = mv_urto;
                state_d  = CALC_Y;
            end
            CALC_Y: begin
                y_sh_d   = mv_new_pos;
                vy_sh_d  = mv_new_v;
                bounce_d = bounce_q | mv_urto;
                state_d  = COMMIT;
            end
            default: begin  // COMMIT
                x_pos_d = x_sh_q;
                y_pos_d = y_sh_q;
                vx_d    = vx_sh_q;
                vy_d    = vy_sh_q;
                urto_d  = bounce_q;
                state_d = RUN;
            end
        endcase

        // LOAD overrides everything, including a COMMIT in the same cycle.
        if (LOAD) begin
            x_pos_d  = X_INIT;
            y_pos_d  = Y_INIT;
            x_sh_d   = X_INIT;
            y_sh_d   = Y_INIT;
            vx_d     = VX;
            vy_d     = VY;
            vx_sh_d  = VX;
            vy_sh_d  = VY;
            bounce_d = 1'b0;
            urto_d   = 1'b0;
            state_d  = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RUN;
            x_pos_q    <= PW'(X0);
            y_pos_q    <= PW'(Y0);
            vx_q       <= '0;
            vy_q       <= '0;
            x_sh_q     <= PW'(X0);
            y_sh_q     <= PW'(Y0);
            vx_sh_q    <= '0;
            vy_sh_q    <= '0;
            modo_q     <= 1'b0;
            bounce_q   <= 1'b0;
            urto_q     <= 1'b0;
            conferma_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            x_sh_q     <= x_sh_d;
            y_sh_q     <= y_sh_d;
            vx_sh_q    <= vx_sh_d;
            vy_sh_q    <= vy_sh_d;
            modo_q     <= modo_d;
            bounce_q   <= bounce_d;
            urto_q     <= urto_d;
            conferma_q <= conferma_d;
        end
    end

    assign CONFERMA = conferma_q;
    assign X_POS    = x_pos_q;
    assign Y_POS    = y_pos_q;
    assign URTO     = urto_q;
    assign OCCUPATO = (state_q != RUN);

endmodule

// File: tb/tb_cornice_mobile.sv
// Self-checking bench for cornice_mobile: directed scenarios plus randomized
// motion and hit tests against an integer reference model.
module tb_cornice_mobile;

    localparam int H  = 1280;
    localparam int V  = 1024;
    localparam int L  = 100;
    localparam int A  = 100;
    localparam int SP = 6;

    logic        CLK = 1'b0;
    logic        RST, FRAME_TICK, LOAD, MODO;
    logic [10:0] X_INIT, Y_INIT, X_CONTROLLO, Y_CONTROLLO;
    logic [5:0]  VX, VY;
    logic        CONFERMA, URTO, OCCUPATO;
    logic [10:0] X_POS, Y_POS;

    int checks   = 0;
    int failures = 0;

    // Reference state: committed position and velocity.
    int mx, my, mvx, mvy;

    cornice_mobile dut (
        .CLK         (CLK),
        .RST         (RST),
        .FRAME_TICK  (FRAME_TICK),
        .LOAD        (LOAD),
        .X_INIT      (X_INIT),
        .Y_INIT      (Y_INIT),
        .VX          (VX),
        .VY          (VY),
        .MODO        (MODO),
        .X_CONTROLLO (X_CONTROLLO),
        .Y_CONTROLLO (Y_CONTROLLO),
        .CONFERMA    (CONFERMA),
        .X_POS       (X_POS),
        .Y_POS       (Y_POS),
        .URTO        (URTO),
        .OCCUPATO    (OCCUPATO)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge CLK);
        #1;
    endtask

    // One axis of motion, straight from the rules: wrap is a true modulo,
    // bounce clamps to the wall and reverses (saturating) velocity.
    function automatic void axis_step(input int p, input int v, input int m, input int s,
                                      input bit modo, output int np, output int nv, output bit b);
        int t;
        t  = p + v;
        nv = v;
        b  = 1'b0;
        if (!modo) begin
            np = ((t % m) + m) % m;
        end else if (t > m - s || t < 0) begin
            np = (t < 0) ? 0 : m - s;
            nv = (v == -32) ? 31 : -v;
            b  = 1'b1;
        end else begin
            np = t;
        end
    endfunction

    function automatic bit in_span(input int c, input int p, input int m, input int sz);
        if (c >= m) return 1'b0;
        return ((((c - p) % m) + m) % m) < sz;
    endfunction

    function automatic bit model_hit(input int xc, input int yc);
        bit outer;
        outer = in_span(xc, mx, H, L) && in_span(yc, my, V, A);
`ifdef CORNICE_EN
        return outer && !(in_span(xc, (mx + SP/2) % H, H, L - SP)
                       && in_span(yc, (my + SP/2) % V, V, A - SP));
`else
        return outer;
`endif
    endfunction

    task automatic do_load(input int x, input int y, input int vx, input int vy);
        int vxv, vyv;
        vxv = vx;
        vyv = vy;
        LOAD   = 1'b1;
        X_INIT = 11'(x);
        Y_INIT = 11'(y);
        VX     = vxv[5:0];
        VY     = vyv[5:0];
        step_clk();
        LOAD = 1'b0;
        mx = x; my = y; mvx = vx; mvy = vy;
    endtask

    // Full update: checks busy flag, hold-until-commit, result at tick+3 and URTO.
    // MODO is scrambled after CALC_X to confirm the Y axis uses the captured mode.
    task automatic do_tick(input string tag);
        int nx, ny, nvx, nvy;
        bit bx, by, modo_s;
        modo_s = MODO;
        axis_step(mx, mvx, H, L, modo_s, nx, nvx, bx);
        axis_step(my, mvy, V, A, modo_s, ny, nvy, by);
        FRAME_TICK = 1'b1;
        step_clk();
        FRAME_TICK = 1'b0;
        check_eq({tag, "_busy"}, 32'(OCCUPATO), 32'd1);
        step_clk();
        MODO = 1'($urandom_range(0, 1));
        step_clk();
        check_eq({tag, "_hold_x"}, 32'(X_POS), 32'(mx));
        step_clk();
        check_eq({tag, "_x"}, 32'(X_POS), 32'(nx));
        check_eq({tag, "_y"}, 32'(Y_POS), 32'(ny));
        check_eq({tag, "_urto"}, 32'(URTO), 32'(bx | by));
        check_eq({tag, "_idle"}, 32'(OCCUPATO), 32'd0);
        MODO = modo_s;
        mx = nx; my = ny; mvx = nvx; mvy = nvy;
    endtask

    task automatic scan_check(input string tag, input int xc, input int yc);
        X_CONTROLLO = 11'(xc);
        Y_CONTROLLO = 11'(yc);
        step_clk();
        check_eq(tag, 32'(CONFERMA), 32'(model_hit(xc, yc)));
    endtask

    initial begin
        RST = 1'b1; FRAME_TICK = 1'b0; LOAD = 1'b0; MODO = 1'b0;
        X_INIT = '0; Y_INIT = '0; VX = '0; VY = '0;
        X_CONTROLLO = 11'd50; Y_CONTROLLO = 11'd50;
        mx = 0; my = 0; mvx = 0; mvy = 0;
        step_clk(); step_clk();
        check_eq("rst_x", 32'(X_POS), 32'd0);
        check_eq("rst_y", 32'(Y_POS), 32'd0);
        check_eq("rst_conf", 32'(CONFERMA), 32'd0);
        check_eq("rst_urto", 32'(URTO), 32'd0);
        check_eq("rst_busy", 32'(OCCUPATO), 32'd0);
        RST = 1'b0;
        step_clk();
        check_eq("rst_hit", 32'(CONFERMA), 32'd1);
        do_tick("zero_vel");

        // Torus wrap on X.
        MODO = 1'b0;
        do_load(1275, 10, 10, 0);
        do_tick("wrap");
        check_eq("wrap_x5", 32'(X_POS), 32'd5);

        // Bounce on the right wall, then travel back.
        MODO = 1'b1;
        do_load(1170, 10, 20, 0);
        do_tick("bnc1");
        check_eq("bnc1_x1180", 32'(X_POS), 32'd1180);
        check_eq("bnc1_urto1", 32'(URTO), 32'd1);
        step_clk();
        check_eq("bnc1_urto_pulse", 32'(URTO), 32'd0);
        do_tick("bnc2");
        check_eq("bnc2_x1160", 32'(X_POS), 32'd1160);

        // Velocity saturation on the left wall.
        do_load(5, 500, -32, 0);
        do_tick("sat1");
        do_tick("sat2");
        check_eq("sat_x31", 32'(X_POS), 32'd31);

        // Hit test across the X wrap seam and outside the active area.
        do_load(1250, 0, 0, 0);
        scan_check("hit_wrap_in", 20, 50);
        scan_check("hit_wrap_out", 80, 50);
        scan_check("hit_left_edge", 1249, 50);
        scan_check("hit_oob", 1300, 50);
        check_eq("hit_oob0", 32'(CONFERMA), 32'd0);

        // LOAD together with FRAME_TICK: load wins, tick dropped.
        MODO = 1'b0;
        do_load(300, 200, 3, 3);
        FRAME_TICK = 1'b1;
        do_load(400, 300, 5, 7);
        FRAME_TICK = 1'b0;
        check_eq("ld_tick_busy", 32'(OCCUPATO), 32'd0);
        step_clk(); step_clk(); step_clk();
        check_eq("ld_tick_x", 32'(X_POS), 32'd400);
        check_eq("ld_tick_y", 32'(Y_POS), 32'd300);

        // LOAD during CALC_Y aborts the update.
        FRAME_TICK = 1'b1;
        step_clk();
        FRAME_TICK = 1'b0;
        step_clk();
        do_load(50, 60, 4, 9);
        check_eq("ld_abort_busy", 32'(OCCUPATO), 32'd0);
        step_clk(); step_clk(); step_clk();
        check_eq("ld_abort_x", 32'(X_POS), 32'd50);
        check_eq("ld_abort_y", 32'(Y_POS), 32'd60);

        // A second tick while busy is ignored: exactly one step happens.
        FRAME_TICK = 1'b1;
        step_clk();
        step_clk();
        FRAME_TICK = 1'b0;
        step_clk(); step_clk();
        check_eq("tick_ign_x", 32'(X_POS), 32'd54);
        check_eq("tick_ign_busy", 32'(OCCUPATO), 32'd0);
        step_clk(); step_clk(); step_clk(); step_clk();
        check_eq("tick_ign_y", 32'(Y_POS), 32'd69);
        mx = 54; my = 69;

        // Frame / rectangle interior.
        do_load(100, 100, 0, 0);
        scan_check("frm_101_150", 101, 150);
        scan_check("frm_150_150", 150, 150);
        scan_check("frm_199_199", 199, 199);
        scan_check("frm_200_150", 200, 150);

        // Reset in the middle of an update.
        do_load(500, 500, 3, 3);
        X_CONTROLLO = 11'd510; Y_CONTROLLO = 11'd510;
        FRAME_TICK = 1'b1;
        step_clk();
        FRAME_TICK = 1'b0;
        check_eq("mid_rst_pre_conf", 32'(CONFERMA), 32'd1);
        RST = 1'b1;
        step_clk();
        RST = 1'b0;
        check_eq("mid_rst_x", 32'(X_POS), 32'd0);
        check_eq("mid_rst_busy", 32'(OCCUPATO), 32'd0);
        check_eq("mid_rst_conf", 32'(CONFERMA), 32'd0);
        step_clk(); step_clk(); step_clk();
        check_eq("mid_rst_nocommit", 32'(X_POS), 32'd0);
        mx = 0; my = 0; mvx = 0; mvy = 0;
        do_tick("post_rst_vel0");

        // Randomized motion and hit tests.
        for (int it = 0; it < 40; it++) begin
            MODO = 1'($urandom_range(0, 1));
            do_load($urandom_range(0, H - 1), $urandom_range(0, V - 1),
                    int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
            for (int k = 0; k < 3; k++) begin
                do_tick($sformatf("rnd%0d_%0d", it, k));
                for (int s = 0; s < 3; s++) begin
                    int xc, yc;
                    if ($urandom_range(0, 7) == 0) begin
                        xc = $urandom_range(H, 2047);
                        yc = $urandom_range(0, V - 1);
                    end else begin
                        xc = (mx + int'($urandom_range(0, 140)) - 20 + H) % H;
                        yc = (my + int'($urandom_range(0, 140)) - 20 + V) % V;
                    end
                    scan_check($sformatf("rnd_hit%0d_%0d_%0d", it, k, s), xc, yc);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
